fetch_decode: RTL and testbench
===============================

// Module: fetch_decode
// PURPOSE
//  Front end of the 8-bit core: fetches 16-bit instruction words from a 32-entry instruction
//  memory and splits them into the opcode/am/rd/rs1/rs2/mem_addr fields consumed by execute.
//  Owns the program counter and resolves JMP/JZ locally using execute's zero_flag.
//  Presents one decoded instruction at a time to execute with a valid/ready handshake.
// PARAMETERS
//  ADDR_W   5    instruction memory address width (32 words); PC wraps modulo 2**ADDR_W
//  INSTR_W  16   instruction word width
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  reset           in   1   asynchronous, active-high; clears all state
//  enable          in   1   1 = run; 0 = freeze FSM and PC (outputs hold)
//  imem_addr       out  5   instruction memory read address
//  imem_rdata      in   16  instruction word, valid one cycle after imem_addr (sync ROM)
//  zero_flag       in   1   execute zero flag, sampled only when resolving JZ
//  exec_ready      in   1   execute accepts the presented instruction this cycle
//  issue_valid     out  1   decoded fields below are valid
//  opcode          out  4   instr[15:12]
//  am              out  1   instr[11]; 0 = register mode, 1 = memory mode
//  rd / rs1        out  3   instr[10:8] / instr[7:5]
//  rs2             out  3   instr[4:2] (meaningful when am=0)
//  mem_addr        out  5   instr[4:0] (meaningful when am=1)
//  instr_mem_addr  out  5   PC of the instruction currently presented
//  halted          out  1   HLT executed; stays 1 until reset
// BEHAVIOUR
//  - Reset: state=FETCH, pc=0, imem_addr=0, every output 0 (issue_valid=0, halted=0).
//  - FSM: FETCH -> WAIT -> ISSUE -> FETCH; HALT is terminal (exit only via reset).
//  - FETCH: imem_addr<=pc; next WAIT. WAIT: ROM latency; capture imem_rdata into instr reg
//    and decode fields at end of cycle; next ISSUE.
//  - ISSUE, normal opcode: issue_valid=1, fields+instr_mem_addr stable; on exec_ready=1:
//    pc<=pc+1 (31 wraps to 0), issue_valid<=0 next cycle, go FETCH. Hold while ready=0.
//  - ISSUE, JMP (4'hE): not presented (issue_valid stays 0); pc<=instr[4:0]; go FETCH.
//  - ISSUE, JZ (4'hF): not presented; pc<=zero_flag ? instr[4:0] : pc+1; go FETCH.
//  - ISSUE, HLT (4'hD): not presented; halted<=1; go HALT; pc frozen.
//  - NOP (4'h0) is presented to execute like any normal opcode.
//  - Latency: fetch to issue_valid = 3 cycles after entering FETCH; best throughput
//    1 instruction / 3 cycles; branch costs 3 cycles and issues nothing.
//  - enable=0: no state, PC or output change in any state; a presented instruction stays
//    presented, and exec_ready is ignored while enable=0.
//  - Simultaneous enable=0 and exec_ready=1: no handshake occurs.
//  - Reset mid-operation (any state, incl. issue_valid=1 or HALT): immediate return to reset
//    values; the in-flight instruction is dropped, not re-presented.
//  - Branch target equal to current pc (self-loop) is legal; JMP to 31 then pc+1 wraps to 0.
// STRUCTURE
//  - Shared package cpu_pkg: OP_NOP=4'h0, OP_HLT=4'hD, OP_JMP=4'hE, OP_JZ=4'hF, all other
//    opcode localparams shared with execute, field bit-position constants, FSM state enum.
//  - One sub-module: instr_field_decode (combinational: 16-bit word -> fields,
//    is_branch, is_halt); also reusable by disassembly checkers in benches.
//  - Instruction memory is external; bench supplies a 32x16 sync-read ROM model.
// TESTING
//  - Reset then ROM[0]=16'h5B7C, ready=1: imem_addr=0, issue_valid at cycle 3 with
//    opcode=0101 am=1 rd=011 rs1=011 mem_addr=11100; instr_mem_addr=0; next fetch addr=1.
//  - Back-pressure: ready=0 for 5 cycles in ISSUE -> fields and issue_valid held, pc stays 0;
//    ready=1 -> one handshake, pc=1.
//  - ROM[1]=JZ 5'd20: zero_flag=1 -> next imem_addr=20; zero_flag=0 -> imem_addr=2;
//    issue_valid never asserted for JZ. JMP 5'd31 then NOP at 31 -> next imem_addr=0 (wrap).
//  - HLT at ROM[2]: halted=1, issue_valid=0, imem_addr frozen for 20 cycles regardless of
//    ready/enable; reset -> halted=0, pc=0.
//  - enable=0 in each of FETCH/WAIT/ISSUE for 4 cycles -> no output change; resume completes
//    normally. Reset asserted while issue_valid=1 -> issue_valid=0 same cycle (async).

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, instruction field positions and fetch/decode FSM states
package cpu_pkg;

  localparam int IMEM_AW     = 5;
  localparam int INSTR_WIDTH = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JZ  = 4'hF;

  // Least-significant bit of each field within the instruction word
  localparam int OPC_LSB   = 12;
  localparam int AM_BIT    = 11;
  localparam int RD_LSB    = 8;
  localparam int RS1_LSB   = 5;
  localparam int RS2_LSB   = 2;
  localparam int MADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fd_state_t;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - instruction memory, execute handshake and decoded-field bundle
interface fetch_decode_if;
  import cpu_pkg::*;

  logic [IMEM_AW-1:0]     imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   zero_flag;
  logic                   exec_ready;
  logic                   issue_valid;
  logic [3:0]             opcode;
  logic                   am;
  logic [2:0]             rd;
  logic [2:0]             rs1;
  logic [2:0]             rs2;
  logic [IMEM_AW-1:0]     mem_addr;
  logic [IMEM_AW-1:0]     instr_mem_addr;
  logic                   halted;

  modport master (
    output imem_addr, issue_valid, opcode, am, rd, rs1, rs2, mem_addr, instr_mem_addr, halted,
    input  imem_rdata, zero_flag, exec_ready
  );

  modport slave (
    input  imem_addr, issue_valid, opcode, am, rd, rs1, rs2, mem_addr, instr_mem_addr, halted,
    output imem_rdata, zero_flag, exec_ready
  );

endinterface

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of an instruction word into its fields
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic                   am,
  output logic [2:0]             rd,
  output logic [2:0]             rs1,
  output logic [2:0]             rs2,
  output logic [IMEM_AW-1:0]     mem_addr,
  output logic                   is_branch,
  output logic                   is_halt
);

  assign opcode    = instr[OPC_LSB +: 4];
  assign am        = instr[AM_BIT];
  assign rd        = instr[RD_LSB +: 3];
  assign rs1       = instr[RS1_LSB +: 3];
  assign rs2       = instr[RS2_LSB +: 3];
  // Overlaps rs2; execute chooses which one to use from am
  assign mem_addr  = instr[MADDR_LSB +: IMEM_AW];
  assign is_branch = is_branch_op(opcode);
  assign is_halt   = (opcode == OP_HLT);

endmodule

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - PC owner: fetches, decodes, resolves JMP/JZ/HLT and issues to execute
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = IMEM_AW,
  parameter int INSTR_W = INSTR_WIDTH
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  fetch_decode_if.master       bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fd_state_t          state, state_nx;
  logic [ADDR_W-1:0]  pc, pc_nx;
  logic [INSTR_W-1:0] instr, instr_nx;

  logic [3:0]         opcode;
  logic               am;
  logic [2:0]         rd, rs1, rs2;
  logic [IMEM_AW-1:0] target;
  logic               is_branch, is_halt;

  instr_field_decode u_decode (
    .instr     (instr),
    .opcode    (opcode),
    .am        (am),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .mem_addr  (target),
    .is_branch (is_branch),
    .is_halt   (is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
    end
  end

  // The ROM registers the address every cycle, so keeping it tied to pc means the
  // word for pc is already on imem_rdata by the time WAIT captures it.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    if (enable) begin
      case (state)
        ST_FETCH: state_nx = ST_WAIT;
        ST_WAIT: begin
          instr_nx = bus.imem_rdata;
          state_nx = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_halt) begin
            state_nx = ST_HALT;
          end else if (opcode == OP_JMP) begin
            pc_nx    = target;
            state_nx = ST_FETCH;
          end else if (opcode == OP_JZ) begin
            pc_nx    = bus.zero_flag ? target : pc + PC_ONE;
            state_nx = ST_FETCH;
          end else if (bus.exec_ready) begin
            pc_nx    = pc + PC_ONE;
            state_nx = ST_FETCH;
          end
        end
        ST_HALT:  state_nx = ST_HALT;
        default:  state_nx = ST_FETCH;
      endcase
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.instr_mem_addr = pc;
  assign bus.issue_valid    = (state == ST_ISSUE) && !is_branch && !is_halt;
  assign bus.halted         = (state == ST_HALT);
  assign bus.opcode         = opcode;
  assign bus.am             = am;
  assign bus.rd             = rd;
  assign bus.rs1            = rs1;
  assign bus.rs2            = rs2;
  assign bus.mem_addr       = target;

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - scoreboard bench for fetch_decode with an ISA-level program model
module tb_fetch_decode;
  import cpu_pkg::*;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  logic [15:0] rom [32];
  int n_tests = 0;
  int n_fail  = 0;
  bit sb_on   = 1'b0;

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] w;
  } exp_t;
  exp_t exp_q[$];

  fetch_decode_if bus();

  fetch_decode dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] fields_of(input logic [15:0] w, input logic [4:0] pc);
    return {8'd0, w[15:12], w[11], w[10:8], w[7:5], w[4:2], w[4:0], pc};
  endfunction

  function automatic logic [31:0] dut_fields();
    return {8'd0, bus.opcode, bus.am, bus.rd, bus.rs1, bus.rs2, bus.mem_addr, bus.instr_mem_addr};
  endfunction

  function automatic logic [31:0] st(input logic h, input logic iv, input logic [4:0] a);
    return {25'd0, h, iv, a};
  endfunction

  function automatic logic [31:0] status();
    return {25'd0, bus.halted, bus.issue_valid, bus.imem_addr};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.exec_ready = 1'b0;
    tick(2);
    check("reset_status", status(), 32'd0);
    check("reset_fields", dut_fields(), 32'd0);
    reset = 1'b0;
  endtask

  // Monitor: a handshake happens at the next rising edge when all three are high
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && !reset && enable && bus.issue_valid && bus.exec_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_issue: pc %0d presented, none required", bus.instr_mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_issue", dut_fields(), fields_of(e.w, e.pc));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [4:0]  pc_m;
    logic [15:0] w;
    logic [3:0]  op;
    bit          zf;
    bit          halt_exp;
    int          r;
    int          steps;
    int          cyc;

    bus.exec_ready = 1'b0;
    bus.zero_flag  = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h5B7C;
    rom[1]  = 16'hF014;
    rom[2]  = 16'hD000;
    rom[20] = 16'hE01F;
    rom[31] = 16'h0000;
    enable = 1'b1;

    // First fetch, back-pressure, JZ taken, JMP to 31, wrap to 0
    do_reset();
    check("fetch_addr0", status(), st(1'b0, 1'b0, 5'd0));
    tick(1);
    check("wait_no_issue", status(), st(1'b0, 1'b0, 5'd0));
    tick(1);
    check("issue_cycle3", status(), st(1'b0, 1'b1, 5'd0));
    check("issue_fields", dut_fields(), fields_of(16'h5B7C, 5'd0));
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_hold", status(), st(1'b0, 1'b1, 5'd0));
    end
    check("bp_fields", dut_fields(), fields_of(16'h5B7C, 5'd0));
    bus.exec_ready = 1'b1;
    bus.zero_flag  = 1'b1;
    tick(1);
    check("handshake_pc1", status(), st(1'b0, 1'b0, 5'd1));
    tick(2);
    check("jz_not_issued", status(), st(1'b0, 1'b0, 5'd1));
    tick(1);
    check("jz_taken", status(), st(1'b0, 1'b0, 5'd20));
    tick(2);
    check("jmp_not_issued", status(), st(1'b0, 1'b0, 5'd20));
    tick(1);
    check("jmp_31", status(), st(1'b0, 1'b0, 5'd31));
    tick(2);
    check("nop_issued", status(), st(1'b0, 1'b1, 5'd31));
    check("nop_fields", dut_fields(), fields_of(16'h0000, 5'd31));
    tick(1);
    check("wrap_0", status(), st(1'b0, 1'b0, 5'd0));

    // JZ not taken, then HLT freezes everything until reset
    do_reset();
    bus.zero_flag  = 1'b0;
    bus.exec_ready = 1'b1;
    tick(3);
    check("pass2_pc1", status(), st(1'b0, 1'b0, 5'd1));
    tick(2);
    check("jz0_not_issued", status(), st(1'b0, 1'b0, 5'd1));
    tick(1);
    check("jz_not_taken", status(), st(1'b0, 1'b0, 5'd2));
    tick(2);
    check("hlt_not_issued", status(), st(1'b0, 1'b0, 5'd2));
    tick(1);
    check("halted", status(), st(1'b1, 1'b0, 5'd2));
    for (int i = 0; i < 20; i++) begin
      enable         = ($urandom_range(0, 1) != 0);
      bus.exec_ready = ($urandom_range(0, 1) != 0);
      tick(1);
      check("halt_frozen", status(), st(1'b1, 1'b0, 5'd2));
    end
    enable = 1'b1;
    do_reset();
    check("after_halt_reset", status(), st(1'b0, 1'b0, 5'd0));

    // enable=0 held for 4 cycles in FETCH, WAIT and ISSUE
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("en_fetch", status(), st(1'b0, 1'b0, 5'd0));
    end
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("en_wait", status(), st(1'b0, 1'b0, 5'd0));
    end
    enable = 1'b1;
    tick(1);
    check("en_resume_issue", status(), st(1'b0, 1'b1, 5'd0));
    check("en_resume_fields", dut_fields(), fields_of(16'h5B7C, 5'd0));
    enable = 1'b0;
    bus.exec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("en_issue", status(), st(1'b0, 1'b1, 5'd0));
    end
    enable = 1'b1;
    tick(1);
    check("en_handshake", status(), st(1'b0, 1'b0, 5'd1));

    // Asynchronous reset while an instruction is presented
    do_reset();
    tick(2);
    check("pre_async", status(), st(1'b0, 1'b1, 5'd0));
    #2 reset = 1'b1;
    #1 check("async_reset", status(), st(1'b0, 1'b0, 5'd0));
    tick(1);
    reset = 1'b0;
    tick(2);
    check("refetch_after_reset", status(), st(1'b0, 1'b1, 5'd0));

    // Random programs against the instruction-level model
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 32; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8)                        op = OP_JMP;
        else if (r < 16)                  op = OP_JZ;
        else if (r < 19 && (p % 2 == 1))  op = OP_HLT;
        else                              op = 4'($urandom_range(0, 12));
        rom[i] = {op, 12'($urandom)};
      end
      zf = ($urandom_range(0, 1) != 0);
      bus.zero_flag = zf;
      exp_q.delete();
      pc_m = 5'd0;
      halt_exp = 1'b0;
      steps = 0;
      while (steps < 300 && exp_q.size() < 16 && !halt_exp) begin
        w = rom[pc_m];
        steps++;
        case (w[15:12])
          4'hD: halt_exp = 1'b1;
          4'hE: pc_m = w[4:0];
          4'hF: pc_m = zf ? w[4:0] : pc_m + 5'd1;
          default: begin
            exp_q.push_back('{pc_m, w});
            pc_m = pc_m + 5'd1;
          end
        endcase
      end

      enable = 1'b1;
      do_reset();
      sb_on = 1'b1;
      cyc = 0;
      while ((exp_q.size() != 0 || (halt_exp && !bus.halted)) && cyc < 3000) begin
        enable         = ($urandom_range(0, 9) != 0);
        bus.exec_ready = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
        tick(1);
        cyc++;
      end
      bus.exec_ready = 1'b0;
      enable = 1'b1;
      sb_on = 1'b0;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      if (halt_exp) check("sb_halt", {30'd0, bus.halted, bus.issue_valid}, 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
